// File: rtl/axi_lite_pkg.sv
// =============================================================================
// Module  : axi_lite_pkg
// Brief   : Shared AXI4-Lite response codes and initiator FSM state encoding.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WR_B  = 3'd2,
        S_RD_AR = 3'd3,
        S_RD_R  = 3'd4,
        S_RSP   = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master.sv
// =============================================================================
// Module  : axi_lite_master
// Brief   : Single-outstanding AXI4-Lite initiator driven by a cmd/rsp pair.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int ERR_CNT_BW_p  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic                     i_cmd_write,
    input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
    input  logic [31:0]              i_cmd_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_write,
    output logic [31:0]              o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    output logic [ERR_CNT_BW_p-1:0]  o_err_cnt,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [31:0]              o_axi_wdata,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [1:0]               i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
    output logic                     o_axi_arvalid,
    input  logic                     i_axi_arready,
    input  logic [31:0]              i_axi_rdata,
    input  logic [1:0]               i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready
);

    localparam logic [ERR_CNT_BW_p-1:0] c_err_one = {{(ERR_CNT_BW_p-1){1'b0}}, 1'b1};

    state_t state_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic   w_aw_fin;
    logic   w_w_fin;
    logic   w_err_sat;

    // A channel counts as finished if it completed earlier or handshakes this cycle.
    assign w_aw_fin  = aw_done_q | (o_axi_awvalid & i_axi_awready);
    assign w_w_fin   = w_done_q  | (o_axi_wvalid  & i_axi_wready);
    assign w_err_sat = &o_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            o_cmd_ready   <= 1'b1;
            o_rsp_valid   <= 1'b0;
            o_rsp_write   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_resp    <= '0;
            o_err_cnt     <= '0;
            o_axi_awaddr  <= '0;
            o_axi_awvalid <= 1'b0;
            o_axi_wdata   <= '0;
            o_axi_wvalid  <= 1'b0;
            o_axi_bready  <= 1'b0;
            o_axi_araddr  <= '0;
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        o_cmd_ready <= 1'b0;
                        o_rsp_write <= i_cmd_write;
                        if (i_cmd_write) begin
                            o_axi_awaddr  <= i_cmd_addr;
                            o_axi_wdata   <= i_cmd_wdata;
                            o_axi_awvalid <= 1'b1;
                            o_axi_wvalid  <= 1'b1;
                            aw_done_q     <= 1'b0;
                            w_done_q      <= 1'b0;
                            state_q       <= S_WR;
                        end else begin
                            o_axi_araddr  <= i_cmd_addr;
                            o_axi_arvalid <= 1'b1;
                            state_q       <= S_RD_AR;
                        end
                    end
                end
                S_WR: begin
                    if (o_axi_awvalid && i_axi_awready) begin
                        o_axi_awvalid <= 1'b0;
                        aw_done_q     <= 1'b1;
                    end
                    if (o_axi_wvalid && i_axi_wready) begin
                        o_axi_wvalid <= 1'b0;
                        w_done_q     <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        o_axi_bready <= 1'b1;
                        state_q      <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (i_axi_bvalid) begin
                        o_rsp_resp   <= i_axi_bresp;
                        o_rsp_rdata  <= '0;
                        o_axi_bready <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        state_q      <= S_RSP;
                        if ((i_axi_bresp != OKAY) && !w_err_sat) begin
                            o_err_cnt <= o_err_cnt + c_err_one;
                        end
                    end
                end
                S_RD_AR: begin
                    if (i_axi_arready) begin
                        o_axi_arvalid <= 1'b0;
                        o_axi_rready  <= 1'b1;
                        state_q       <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (i_axi_rvalid) begin
                        o_rsp_resp   <= i_axi_rresp;
                        o_rsp_rdata  <= i_axi_rdata;
                        o_axi_rready <= 1'b0;
                        o_rsp_valid  <= 1'b1;
                        state_q      <= S_RSP;
                        if ((i_axi_rresp != OKAY) && !w_err_sat) begin
                            o_err_cnt <= o_err_cnt + c_err_one;
                        end
                    end
                end
                S_RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// =============================================================================
// Module  : tb_axi_lite_master
// Brief   : Self-checking bench for axi_lite_master with a small register slave.
// Revision: 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 12;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid, i_cmd_write, i_rsp_ready;
    logic [AW-1:0] i_cmd_addr;
    logic [31:0]   i_cmd_wdata;
    logic          o_cmd_ready, o_rsp_valid, o_rsp_write;
    logic [31:0]   o_rsp_rdata;
    logic [1:0]    o_rsp_resp;
    logic [EW-1:0] o_err_cnt;
    logic [AW-1:0] o_axi_awaddr, o_axi_araddr;
    logic [31:0]   o_axi_wdata;
    logic          o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;

    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [31:0]   s_rdata;

    always #5 clk = ~clk;

    axi_lite_master #(.AXI_ADDR_BW_p(AW), .ERR_CNT_BW_p(EW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_err_cnt(o_err_cnt),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(s_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(s_wready),
        .i_axi_bresp(s_bresp), .i_axi_bvalid(s_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(s_arready),
        .i_axi_rdata(s_rdata), .i_axi_rresp(s_rresp), .i_axi_rvalid(s_rvalid),
        .o_axi_rready(o_axi_rready)
    );

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [EW-1:0] exp_err  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave: handshakes are sampled on posedge, slave outputs change on negedge.
    logic          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic          got_aw = 1'b0, got_w = 1'b0;
    logic [AW-1:0] cap_awaddr, cap_araddr;
    logic [31:0]   cap_wdata;
    logic [31:0]   reg0 = '0;
    int            aw_hold = 0;
    logic          b_hold = 1'b0;

    always @(posedge clk) begin
        hs_aw = o_axi_awvalid && s_awready;
        hs_w  = o_axi_wvalid  && s_wready;
        hs_b  = s_bvalid      && o_axi_bready;
        hs_ar = o_axi_arvalid && s_arready;
        hs_r  = s_rvalid      && o_axi_rready;
        if (hs_aw) cap_awaddr = o_axi_awaddr;
        if (hs_w)  cap_wdata  = o_axi_wdata;
        if (hs_ar) cap_araddr = o_axi_araddr;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            s_bvalid  = 1'b0;
            s_rvalid  = 1'b0;
            got_aw    = 1'b0;
            got_w     = 1'b0;
            s_awready = 1'b1;
            reg0      = '0;
        end else begin
            if (hs_b) s_bvalid = 1'b0;
            if (hs_r) s_rvalid = 1'b0;
            if (hs_aw) got_aw = 1'b1;
            if (hs_w)  got_w  = 1'b1;
            if (got_aw && got_w && !s_bvalid && !b_hold) begin
                s_bresp = OKAY;
                if (cap_awaddr == 12'h000) reg0 = cap_wdata;
                else if (cap_awaddr == 12'h008) s_bresp = SLVERR;
                s_bvalid = 1'b1;
                got_aw   = 1'b0;
                got_w    = 1'b0;
            end
            if (hs_ar) begin
                s_rresp = OKAY;
                s_rdata = 32'h0;
                if (cap_araddr == 12'h000) s_rdata = reg0;
                else if (cap_araddr == 12'h004) begin
                    s_rdata = 32'hDEADDEAD;
                    s_rresp = SLVERR;
                end
                s_rvalid = 1'b1;
            end
            if (aw_hold > 0 && o_axi_awvalid) begin
                s_awready = 1'b0;
                aw_hold--;
            end else begin
                s_awready = 1'b1;
            end
        end
    end

    // Scoreboard: compare each response at its handshake edge (pre-edge values).
    always @(posedge clk) begin
        if (rst_n && o_rsp_valid && i_rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rsp", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_write", o_rsp_write, mon_e.write);
                chk("rsp_rdata", o_rsp_rdata, mon_e.rdata);
                chk("rsp_resp",  o_rsp_resp,  mon_e.resp);
                if (mon_e.resp != OKAY && exp_err != '1) exp_err++;
                chk("err_cnt", o_err_cnt, exp_err);
            end
        end
    end

    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input logic [31:0] erd, input logic [1:0] eresp);
        exp_t e;
        int   n = 0;
        e.write = wr;
        e.rdata = erd;
        e.resp  = eresp;
        sb_q.push_back(e);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = addr;
        i_cmd_wdata = wd;
        while (!o_cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lat;
        int          aw_cyc, w_cyc, b_early;
        logic [63:0] snap;

        i_cmd_valid = 1'b0;
        i_cmd_write = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_wdata = '0;
        i_rsp_ready = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
        s_bvalid  = 1'b0; s_rvalid = 1'b0;
        s_bresp   = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0; hs_ar = 1'b0; hs_r = 1'b0;
        cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_awvalid", o_axi_awvalid, 0);
        chk("rst_wvalid", o_axi_wvalid, 0);
        chk("rst_arvalid", o_axi_arvalid, 0);
        chk("rst_bready_rready", {o_axi_bready, o_axi_rready}, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_rsp_data", {o_rsp_rdata, o_rsp_resp, o_rsp_write}, 0);
        chk("rst_addr", {o_axi_awaddr, o_axi_araddr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write with latency measurement: accept edge -> rsp_valid three cycles later
        do_cmd(1'b1, 12'h000, 32'hA5A5_0F0F, 32'h0, OKAY);
        lat = 1;
        while (!o_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t1_latency", lat, 3);
        wait_rsp();
        chk("t1_slave_reg", reg0, 32'hA5A5_0F0F);

        do_cmd(1'b0, 12'h000, 32'h0, 32'hA5A5_0F0F, OKAY);
        wait_rsp();

        do_cmd(1'b0, 12'h004, 32'h0, 32'hDEADDEAD, SLVERR);
        wait_rsp();
        do_cmd(1'b1, 12'h008, 32'h1234_5678, 32'h0, SLVERR);
        wait_rsp();
        chk("t3_err_cnt", o_err_cnt, 2);

        // AW stalled for three cycles while W goes straight through
        aw_hold = 3;
        do_cmd(1'b1, 12'h010, 32'h0000_BEEF, 32'h0, OKAY);
        aw_cyc = 0; w_cyc = 0; b_early = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_axi_awvalid) begin
                aw_cyc++;
                chk("t4_awaddr_stable", o_axi_awaddr, 12'h010);
            end
            if (o_axi_wvalid) w_cyc++;
            if (o_axi_bready && o_axi_awvalid) b_early++;
            @(negedge clk);
        end
        chk("t4_aw_cycles", aw_cyc, 4);
        chk("t4_w_cycles", w_cyc, 1);
        chk("t4_b_before_aw", b_early, 0);
        wait_rsp();

        // Response back-pressure with a queued command
        i_rsp_ready = 1'b0;
        do_cmd(1'b1, 12'h000, 32'h1111_2222, 32'h0, OKAY);
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rsp_valid_seen", o_rsp_valid, 1);
        snap = {29'h0, o_rsp_write, o_rsp_rdata, o_rsp_resp};
        begin
            exp_t e2;
            e2.write = 1'b0;
            e2.rdata = 32'h1111_2222;
            e2.resp  = OKAY;
            sb_q.push_back(e2);
        end
        i_cmd_valid = 1'b1;
        i_cmd_write = 1'b0;
        i_cmd_addr  = 12'h000;
        repeat (5) begin
            @(negedge clk);
            chk("t5_rsp_stable", {29'h0, o_rsp_write, o_rsp_rdata, o_rsp_resp}, snap);
            chk("t5_rsp_valid_held", o_rsp_valid, 1);
            chk("t5_cmd_ready_low", o_cmd_ready, 0);
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_cmd_ready_after_hs", o_cmd_ready, 1);
        chk("t5_rsp_valid_dropped", o_rsp_valid, 0);
        @(negedge clk);
        chk("t5_cmd_accepted", o_cmd_ready, 0);
        chk("t5_arvalid", o_axi_arvalid, 1);
        i_cmd_valid = 1'b0;
        wait_rsp();

        // Reset while waiting for B
        b_hold = 1'b1;
        do_cmd(1'b1, 12'h00C, 32'hCAFE_F00D, 32'h0, OKAY);
        n = 0;
        while (!o_axi_bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_wr_b", o_axi_bready, 1);
        rst_n = 1'b0;
        sb_q.delete();
        exp_err = '0;
        #1;
        chk("t6_bready", o_axi_bready, 0);
        chk("t6_aw_w_valid", {o_axi_awvalid, o_axi_wvalid}, 0);
        chk("t6_cmd_ready", o_cmd_ready, 1);
        chk("t6_err_cnt", o_err_cnt, 0);
        b_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd(1'b0, 12'h000, 32'h0, 32'h0, OKAY);
        wait_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
